// File: rtl/picorv32_mem_model.sv
// Behavioural single-port bench memory for the picorv32 native bus: fixed-latency
// responses, backdoor load, tohost end-of-test detection, fault/protocol flags, counters.
module picorv32_mem_model #(
  parameter int unsigned MEM_WORDS   = 1024,
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
  parameter int unsigned WAIT_CYCLES = 0,
  parameter logic [31:0] TOHOST_ADDR = 32'h1000_0000,
  parameter logic [31:0] ERR_DATA    = 32'hDEAD_BEEF
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         mem_valid,
  input  logic                         mem_instr,
  input  logic [31:0]                  mem_addr,
  input  logic [31:0]                  mem_wdata,
  input  logic [3:0]                   mem_wstrb,
  output logic                         mem_ready,
  output logic [31:0]                  mem_rdata,
  input  logic                         ld_en,
  input  logic [$clog2(MEM_WORDS)-1:0] ld_addr,
  input  logic [31:0]                  ld_data,
  output logic                         done,
  output logic [31:0]                  done_code,
  output logic                         fault,
  output logic [31:0]                  fault_addr,
  output logic                         proto_err,
  output logic [31:0]                  fetch_cnt,
  output logic [31:0]                  rd_cnt,
  output logic [31:0]                  wr_cnt
);
  localparam int          AW    = $clog2(MEM_WORDS);
  localparam logic [32:0] SPAN  = 33'(MEM_WORDS) << 2;
  localparam logic [3:0]  WAIT4 = 4'(WAIT_CYCLES);
  localparam logic [31:0] TOHOST_W = {TOHOST_ADDR[31:2], 2'b00};

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;

  state_t      state_q, state_d;
  logic [3:0]  wait_q, wait_d;
  logic [31:0] addr_q, addr_d, wdata_q, wdata_d;
  logic [3:0]  wstrb_q, wstrb_d;
  logic        instr_q, instr_d;
  logic        ready_q, ready_d;
  logic [31:0] rdata_q, rdata_d;
  logic        done_q, done_d, fault_q, fault_d, proto_q, proto_d;
  logic [31:0] code_q, code_d, faddr_q, faddr_d;
  logic [31:0] fetch_q, fetch_d, rd_q, rd_d, wr_q, wr_d;

  logic [31:0] mem_q [MEM_WORDS];

  logic [31:0] word_addr, offset;
  logic [AW-1:0] idx;
  logic is_tohost, in_range, bus_wr;

  always_comb begin
    word_addr = {addr_q[31:2], 2'b00};
    offset    = word_addr - BASE_ADDR;
    idx       = AW'(offset >> 2);
    is_tohost = (word_addr == TOHOST_W) && (wstrb_q != 4'b0);
    in_range  = (word_addr >= BASE_ADDR) && ({1'b0, offset} < SPAN);
    bus_wr    = (state_q == S_RESP) && !is_tohost && in_range && (wstrb_q != 4'b0);
  end

  always_comb begin
    state_d = state_q;
    wait_d  = wait_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    wstrb_d = wstrb_q;
    instr_d = instr_q;
    ready_d = 1'b0;
    rdata_d = rdata_q;
    done_d  = done_q;
    code_d  = code_q;
    fault_d = fault_q;
    faddr_d = faddr_q;
    proto_d = proto_q;
    fetch_d = fetch_q;
    rd_d    = rd_q;
    wr_d    = wr_q;
    case (state_q)
      S_IDLE: begin
        // The ready cycle still sees the old request's valid; never re-accept it.
        if (mem_valid && !ready_q) begin
          addr_d  = mem_addr;
          wdata_d = mem_wdata;
          wstrb_d = mem_wstrb;
          instr_d = mem_instr;
          wait_d  = WAIT4 - 4'd1;
          state_d = (WAIT_CYCLES == 0) ? S_RESP : S_WAIT;
        end
      end
      S_WAIT: begin
        if (!mem_valid) proto_d = 1'b1;
        if (wait_q == 4'd0) state_d = S_RESP;
        else                wait_d  = wait_q - 4'd1;
      end
      S_RESP: begin
        ready_d = 1'b1;
        state_d = S_IDLE;
        if (wstrb_q != 4'b0) wr_d    = wr_q + 32'd1;
        else if (instr_q)    fetch_d = fetch_q + 32'd1;
        else                 rd_d    = rd_q + 32'd1;
        if (is_tohost) begin
          done_d = 1'b1;
          if (!done_q) code_d = wdata_q;
        end else if (!in_range) begin
          fault_d = 1'b1;
          if (!fault_q) faddr_d = addr_q;
          if (wstrb_q == 4'b0) rdata_d = ERR_DATA;
        end else if (wstrb_q == 4'b0) begin
          rdata_d = mem_q[idx];
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      wait_q  <= 4'd0;
      addr_q  <= 32'd0;
      wdata_q <= 32'd0;
      wstrb_q <= 4'd0;
      instr_q <= 1'b0;
      ready_q <= 1'b0;
      rdata_q <= 32'd0;
      done_q  <= 1'b0;
      code_q  <= 32'd0;
      fault_q <= 1'b0;
      faddr_q <= 32'd0;
      proto_q <= 1'b0;
      fetch_q <= 32'd0;
      rd_q    <= 32'd0;
      wr_q    <= 32'd0;
    end else begin
      state_q <= state_d;
      wait_q  <= wait_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      wstrb_q <= wstrb_d;
      instr_q <= instr_d;
      ready_q <= ready_d;
      rdata_q <= rdata_d;
      done_q  <= done_d;
      code_q  <= code_d;
      fault_q <= fault_d;
      faddr_q <= faddr_d;
      proto_q <= proto_d;
      fetch_q <= fetch_d;
      rd_q    <= rd_d;
      wr_q    <= wr_d;
    end
  end

  // Array is deliberately unreset so preloaded programs survive reset; bus write beats backdoor.
  always_ff @(posedge clk) begin
    if (ld_en && !(bus_wr && (ld_addr == idx))) mem_q[ld_addr] <= ld_data;
    if (bus_wr) begin
      for (int b = 0; b < 4; b++) begin
        if (wstrb_q[b]) mem_q[idx][8*b +: 8] <= wdata_q[8*b +: 8];
      end
    end
  end

  assign mem_ready  = ready_q;
  assign mem_rdata  = rdata_q;
  assign done       = done_q;
  assign done_code  = code_q;
  assign fault      = fault_q;
  assign fault_addr = faddr_q;
  assign proto_err  = proto_q;
  assign fetch_cnt  = fetch_q;
  assign rd_cnt     = rd_q;
  assign wr_cnt     = wr_q;
endmodule

// File: tb/tb_picorv32_mem_model.sv
// Bench for picorv32_mem_model: three instances (wait 0/3/2) driven by a tiny RV32I
// interpreter and random bus traffic, checked against a word-array reference model.
module tb_picorv32_mem_model;
  localparam int N = 3;
  localparam int WORDS = 64;
  localparam logic [31:0] TOHOST = 32'h1000_0000;
  localparam logic [31:0] ERR = 32'hDEAD_BEEF;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst [N];
  logic        mem_valid [N], mem_instr [N], ld_en [N];
  logic [31:0] mem_addr [N], mem_wdata [N], ld_data [N];
  logic [3:0]  mem_wstrb [N];
  logic [5:0]  ld_addr [N];
  logic        mem_ready [N], done [N], fault [N], proto_err [N];
  logic [31:0] mem_rdata [N], done_code [N], fault_addr [N], fetch_cnt [N], rd_cnt [N], wr_cnt [N];

  for (genvar g = 0; g < N; g++) begin : g_dut
    picorv32_mem_model #(
      .MEM_WORDS(WORDS), .BASE_ADDR(32'h0), .WAIT_CYCLES(g == 0 ? 0 : (g == 1 ? 3 : 2)),
      .TOHOST_ADDR(TOHOST), .ERR_DATA(ERR)
    ) u_dut (
      .clk(clk), .reset(rst[g]),
      .mem_valid(mem_valid[g]), .mem_instr(mem_instr[g]), .mem_addr(mem_addr[g]),
      .mem_wdata(mem_wdata[g]), .mem_wstrb(mem_wstrb[g]),
      .mem_ready(mem_ready[g]), .mem_rdata(mem_rdata[g]),
      .ld_en(ld_en[g]), .ld_addr(ld_addr[g]), .ld_data(ld_data[g]),
      .done(done[g]), .done_code(done_code[g]), .fault(fault[g]), .fault_addr(fault_addr[g]),
      .proto_err(proto_err[g]), .fetch_cnt(fetch_cnt[g]), .rd_cnt(rd_cnt[g]), .wr_cnt(wr_cnt[g])
    );
  end

  int checks = 0;
  int passed = 0;

  // Reference model state per instance
  logic [31:0] m_mem [N][WORDS];
  logic [31:0] m_rdata [N], m_code [N], m_faddr [N];
  logic [31:0] m_fetch [N], m_rd [N], m_wr [N];
  bit          m_done [N], m_fault [N];

  function automatic int wc(input int d);
    return (d == 0) ? 0 : ((d == 1) ? 3 : 2);
  endfunction

  task automatic model_reset(input int d);
    m_rdata[d] = 0; m_code[d] = 0; m_faddr[d] = 0;
    m_fetch[d] = 0; m_rd[d] = 0; m_wr[d] = 0;
    m_done[d] = 0; m_fault[d] = 0;
  endtask

  task automatic load(input int d, input int w, input logic [31:0] v);
    @(negedge clk);
    ld_en[d] = 1'b1; ld_addr[d] = 6'(w); ld_data[d] = v;
    @(negedge clk);
    ld_en[d] = 1'b0;
    m_mem[d][w] = v;
  endtask

  // One complete bus transaction; returns DUT data, model data, edges from accept to ready,
  // and whether ready had dropped again one edge later.
  task automatic access(input int d, input logic [31:0] a, input logic [31:0] wd,
                        input logic [3:0] st, input bit ins,
                        output logic [31:0] got, output logic [31:0] exp,
                        output int lat, output bit pulse_ok);
    logic [31:0] wa;
    int idx;
    wa = {a[31:2], 2'b00};
    exp = m_rdata[d];
    if (st != 0) m_wr[d]++;
    else if (ins) m_fetch[d]++;
    else m_rd[d]++;
    if (wa == TOHOST && st != 0) begin
      if (!m_done[d]) m_code[d] = wd;
      m_done[d] = 1;
    end else if (wa >= 32'(WORDS * 4)) begin
      if (!m_fault[d]) m_faddr[d] = a;
      m_fault[d] = 1;
      if (st == 0) exp = ERR;
    end else begin
      idx = int'(wa >> 2);
      if (st == 0) exp = m_mem[d][idx];
      else for (int b = 0; b < 4; b++) if (st[b]) m_mem[d][idx][8*b +: 8] = wd[8*b +: 8];
    end
    m_rdata[d] = exp;

    @(negedge clk);
    mem_valid[d] = 1'b1; mem_addr[d] = a; mem_wdata[d] = wd; mem_wstrb[d] = st; mem_instr[d] = ins;
    @(posedge clk);
    lat = 0;
    do begin
      @(posedge clk); #1; lat++;
    end while (mem_ready[d] !== 1'b1 && lat < 50);
    got = mem_rdata[d];
    @(posedge clk); #1;
    pulse_ok = (lat < 50) && (mem_ready[d] === 1'b0);
    mem_valid[d] = 1'b0; mem_wstrb[d] = 4'b0; mem_instr[d] = 1'b0;
  endtask

  // Minimal RV32I interpreter acting as the core; stops after a store to tohost.
  task automatic run_prog(input int d, output int bad);
    logic [31:0] r [32];
    logic [31:0] pc, ins, e, addr, g;
    int lat, steps;
    bit pok, stop;
    for (int i = 0; i < 32; i++) r[i] = 0;
    pc = 0; bad = 0; steps = 0; stop = 0;
    while (!stop && steps < 20) begin
      access(d, pc, 32'h0, 4'h0, 1'b1, ins, e, lat, pok);
      if (lat != wc(d) + 1 || !pok) bad++;
      case (ins[6:0])
        7'h13: r[ins[11:7]] = r[ins[19:15]] + {{20{ins[31]}}, ins[31:20]};
        7'h37: r[ins[11:7]] = {ins[31:12], 12'h0};
        7'h33: case (ins[14:12])
                 3'd0: r[ins[11:7]] = ins[30] ? r[ins[19:15]] - r[ins[24:20]] : r[ins[19:15]] + r[ins[24:20]];
                 3'd6: r[ins[11:7]] = r[ins[19:15]] | r[ins[24:20]];
                 3'd7: r[ins[11:7]] = r[ins[19:15]] & r[ins[24:20]];
                 default: ;
               endcase
        7'h23: begin
          addr = r[ins[19:15]] + {{20{ins[31]}}, ins[31:25], ins[11:7]};
          access(d, addr, r[ins[24:20]], 4'hF, 1'b0, g, e, lat, pok);
          if (lat != wc(d) + 1 || !pok) bad++;
          if (addr == TOHOST) stop = 1;
        end
        default: ;
      endcase
      r[0] = 0;
      pc += 4;
      steps++;
    end
    if (!stop) bad++;
  endtask

  task automatic test_reset;
    for (int d = 0; d < N; d++) begin
      checks++;
      if ({mem_ready[d], done[d], fault[d], proto_err[d]} !== 4'b0) $display("FAIL reset_flags[%0d]: got %b want 0000", d, {mem_ready[d], done[d], fault[d], proto_err[d]});
      else passed++;
      checks++;
      if ({mem_rdata[d], done_code[d], fault_addr[d]} !== 96'b0) $display("FAIL reset_data[%0d]: got %h %h %h want 0", d, mem_rdata[d], done_code[d], fault_addr[d]);
      else passed++;
      checks++;
      if ({fetch_cnt[d], rd_cnt[d], wr_cnt[d]} !== 96'b0) $display("FAIL reset_cnt[%0d]: got %0d %0d %0d want 0", d, fetch_cnt[d], rd_cnt[d], wr_cnt[d]);
      else passed++;
    end
  endtask

  task automatic test_program(input int d);
    logic [31:0] prog [9] = '{32'h00500093, 32'h00A00113, 32'h002081B3, 32'h40208233,
                              32'h0020F2B3, 32'h0020E333, 32'h100003B7, 32'h0033A023, 32'h0000006F};
    int bad;
    for (int i = 0; i < 9; i++) load(d, i, prog[i]);
    run_prog(d, bad);
    checks++;
    if (bad != 0) $display("FAIL prog_latency[%0d]: got %0d bad handshakes want 0 (latency %0d)", d, bad, wc(d) + 1);
    else passed++;
    checks++;
    if (done[d] !== 1'b1 || done_code[d] !== 32'd15) $display("FAIL prog_done[%0d]: got done=%b code=%0d want 1/15", d, done[d], done_code[d]);
    else passed++;
    checks++;
    if (wr_cnt[d] !== 32'd1 || fault[d] !== 1'b0) $display("FAIL prog_wr_fault[%0d]: got wr=%0d fault=%b want 1/0", d, wr_cnt[d], fault[d]);
    else passed++;
    checks++;
    if (fetch_cnt[d] !== m_fetch[d] || fetch_cnt[d] < 7) $display("FAIL prog_fetch[%0d]: got %0d want %0d", d, fetch_cnt[d], m_fetch[d]);
    else passed++;
  endtask

  task automatic test_reset_abort;
    logic [31:0] g, e;
    int lat;
    bit pok, seen;
    load(1, 5, 32'h55AA_55AA);
    load(1, 9, 32'h1234_5678);
    @(negedge clk);
    mem_valid[1] = 1'b1; mem_addr[1] = 32'd20; mem_wdata[1] = 32'hFFFF_FFFF; mem_wstrb[1] = 4'hF;
    @(posedge clk);
    @(negedge clk);
    rst[1] = 1'b1; mem_valid[1] = 1'b0; mem_wstrb[1] = 4'h0;
    seen = 0;
    repeat (6) begin
      @(posedge clk); #1;
      if (mem_ready[1] !== 1'b0) seen = 1;
    end
    @(negedge clk);
    rst[1] = 1'b0;
    model_reset(1);
    @(posedge clk); #1;
    checks++;
    if (seen) $display("FAIL abort_ready: got mem_ready=1 during reset want 0");
    else passed++;
    checks++;
    if ({fetch_cnt[1], rd_cnt[1], wr_cnt[1]} !== 96'b0 || done[1] !== 1'b0) $display("FAIL abort_cnt: got %0d %0d %0d done=%b want 0", fetch_cnt[1], rd_cnt[1], wr_cnt[1], done[1]);
    else passed++;
    access(1, 32'd20, 32'h0, 4'h0, 1'b0, g, e, lat, pok);
    checks++;
    if (g !== 32'h55AA_55AA || g !== e) $display("FAIL abort_word5: got %h want %h", g, e);
    else passed++;
    access(1, 32'd36, 32'h0, 4'h0, 1'b0, g, e, lat, pok);
    checks++;
    if (g !== e || rd_cnt[1] !== 32'd2) $display("FAIL abort_preload: got %h rd=%0d want %h rd=2", g, rd_cnt[1], e);
    else passed++;
  endtask

  task automatic test_strobe;
    logic [31:0] g, e;
    int lat;
    bit pok;
    load(2, 2, 32'hAABB_CCDD);
    access(2, 32'd8, 32'h1122_3344, 4'b0101, 1'b0, g, e, lat, pok);
    checks++;
    if (g !== e) $display("FAIL strobe_wr_rdata: got %h want %h", g, e);
    else passed++;
    access(2, 32'd8, 32'h0, 4'h0, 1'b0, g, e, lat, pok);
    checks++;
    if (g !== 32'hAA22_CC44 || lat != 3 || !pok) $display("FAIL strobe_read: got %h lat=%0d want aa22cc44 lat=3", g, lat);
    else passed++;
  endtask

  task automatic test_oob;
    logic [31:0] g, e;
    int lat;
    bit pok;
    access(2, 32'(WORDS * 4), 32'h0, 4'h0, 1'b0, g, e, lat, pok);
    checks++;
    if (g !== ERR || fault[2] !== 1'b1 || fault_addr[2] !== 32'(WORDS * 4)) $display("FAIL oob_first: got %h f=%b fa=%h want %h 1 %h", g, fault[2], fault_addr[2], ERR, WORDS * 4);
    else passed++;
    access(2, 32'h0000_0306, 32'h9999_9999, 4'hF, 1'b0, g, e, lat, pok);
    checks++;
    if (fault_addr[2] !== m_faddr[2] || rd_cnt[2] !== m_rd[2] || wr_cnt[2] !== m_wr[2]) $display("FAIL oob_second: got fa=%h rd=%0d wr=%0d want %h %0d %0d", fault_addr[2], rd_cnt[2], wr_cnt[2], m_faddr[2], m_rd[2], m_wr[2]);
    else passed++;
  endtask

  task automatic test_proto;
    logic [31:0] g, e;
    int lat;
    bit pok;
    @(negedge clk);
    mem_valid[2] = 1'b1; mem_addr[2] = 32'd12; mem_wdata[2] = 32'hCAFE_F00D; mem_wstrb[2] = 4'hF;
    @(posedge clk);
    @(negedge clk);
    mem_valid[2] = 1'b0;
    lat = 1;
    while (mem_ready[2] !== 1'b1 && lat < 50) begin
      @(posedge clk); #1;
      if (mem_ready[2] !== 1'b1) lat++;
    end
    m_mem[2][3] = 32'hCAFE_F00D; m_wr[2]++;
    @(negedge clk);
    mem_wstrb[2] = 4'h0;
    checks++;
    if (lat != 3 || proto_err[2] !== 1'b1) $display("FAIL proto_flag: got lat=%0d proto=%b want 3/1", lat, proto_err[2]);
    else passed++;
    access(2, 32'd12, 32'h0, 4'h0, 1'b0, g, e, lat, pok);
    checks++;
    if (g !== 32'hCAFE_F00D) $display("FAIL proto_complete: got %h want cafef00d", g);
    else passed++;

    load(2, 7, 32'h0BAD_F00D);
    @(negedge clk);
    mem_valid[2] = 1'b1; mem_addr[2] = 32'd28; mem_wdata[2] = 32'h7777_AAAA; mem_wstrb[2] = 4'hF;
    @(posedge clk);
    repeat (3) @(negedge clk);
    ld_en[2] = 1'b1; ld_addr[2] = 6'd7; ld_data[2] = 32'h5151_5151;
    @(posedge clk); #1;
    checks++;
    if (mem_ready[2] !== 1'b1) $display("FAIL collide_ready: got %b want 1", mem_ready[2]);
    else passed++;
    @(negedge clk);
    ld_en[2] = 1'b0; mem_valid[2] = 1'b0; mem_wstrb[2] = 4'h0;
    m_mem[2][7] = 32'h7777_AAAA; m_wr[2]++;
    access(2, 32'd28, 32'h0, 4'h0, 1'b0, g, e, lat, pok);
    checks++;
    if (g !== 32'h7777_AAAA || wr_cnt[2] !== m_wr[2]) $display("FAIL collide_data: got %h wr=%0d want 7777aaaa wr=%0d", g, wr_cnt[2], m_wr[2]);
    else passed++;
  endtask

  task automatic test_random;
    logic [31:0] a, g, e;
    logic [3:0] st;
    int lat, bad;
    bit pok, ins;
    for (int w = 0; w < WORDS; w++) load(0, w, $urandom);
    bad = 0;
    for (int i = 0; i < 60; i++) begin
      if ($urandom_range(9) == 0) begin
        load(0, $urandom_range(WORDS - 1), $urandom);
      end else begin
        if ($urandom_range(7) == 0) a = 32'(WORDS * 4) + ($urandom & 32'hFFF);
        else a = (32'($urandom_range(WORDS - 1)) << 2) | 32'($urandom_range(3));
        st = ($urandom_range(1) == 1) ? 4'($urandom_range(15, 1)) : 4'h0;
        ins = (st == 0) && ($urandom_range(1) == 1);
        access(0, a, $urandom, st, ins, g, e, lat, pok);
        if (lat != 1 || !pok) bad++;
        checks++;
        if (g !== e) $display("FAIL rand_rdata[%0d]: addr=%h got %h want %h", i, a, g, e);
        else passed++;
      end
    end
    checks++;
    if (bad != 0) $display("FAIL rand_handshake: got %0d bad want 0", bad);
    else passed++;
    checks++;
    if (fetch_cnt[0] !== m_fetch[0] || rd_cnt[0] !== m_rd[0] || wr_cnt[0] !== m_wr[0]) $display("FAIL rand_cnt: got %0d %0d %0d want %0d %0d %0d", fetch_cnt[0], rd_cnt[0], wr_cnt[0], m_fetch[0], m_rd[0], m_wr[0]);
    else passed++;
    checks++;
    if (fault[0] !== m_fault[0] || (m_fault[0] && fault_addr[0] !== m_faddr[0]) || done_code[0] !== m_code[0]) $display("FAIL rand_flags: got f=%b fa=%h code=%h want %b %h %h", fault[0], fault_addr[0], done_code[0], m_fault[0], m_faddr[0], m_code[0]);
    else passed++;
  endtask

  initial begin
    for (int d = 0; d < N; d++) begin
      rst[d] = 1'b1; mem_valid[d] = 1'b0; mem_instr[d] = 1'b0; mem_addr[d] = 0;
      mem_wdata[d] = 0; mem_wstrb[d] = 0; ld_en[d] = 1'b0; ld_addr[d] = 0; ld_data[d] = 0;
      model_reset(d);
    end
    repeat (3) @(negedge clk);
    for (int d = 0; d < N; d++) rst[d] = 1'b0;
    @(posedge clk); #1;
    test_reset();
    test_program(0);
    test_program(1);
    test_reset_abort();
    test_strobe();
    test_oob();
    test_proto();
    test_random();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule
